// File: rtl/tff_bank_counter_if.sv
// Bus bundle for tff_bank_counter: control, load path and registered state outputs.
// The ovf/ovf_clr pair only exists when TFF_BANK_OVF_STICKY_EN is defined.
interface tff_bank_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] t;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;
`ifdef TFF_BANK_OVF_STICKY_EN
    logic             ovf;
    logic             ovf_clr;

    modport master (output en, mode, t, load, din, ovf_clr, input q, qbar, tc, ovf);
    modport slave  (input en, mode, t, load, din, ovf_clr, output q, qbar, tc, ovf);
`else
    modport master (output en, mode, t, load, din, input q, qbar, tc);
    modport slave  (input en, mode, t, load, din, output q, qbar, tc);
`endif
endinterface

// File: rtl/tff_bank_counter.sv
// WIDTH-bit toggle bank / modulo-(MAX+1) up-down counter with clamped parallel load and tc pulse.
// Optional sticky wrap flag (ovf, ovf_clr) enabled by defining TFF_BANK_OVF_STICKY_EN.
module tff_bank_counter #(
    parameter int WIDTH   = 8,
    parameter int MAX     = 255,
    parameter int RST_VAL = 0
) (
    input  logic               clk,
    input  logic               rst,
    tff_bank_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ZERO_V = '0;
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] toggled;
    logic             tc_reg;
    logic             tc_next;

    // Each bit is an independent toggle cell; qbar is a pure inversion of the state.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign toggled[gi]  = q_reg[gi] ^ bus.t[gi];
            assign bus.qbar[gi] = ~q_reg[gi];
        end
    endgenerate

    always_comb begin
        q_next  = q_reg;
        tc_next = 1'b0;
        if (bus.load) begin
            q_next = (bus.din > MAX_V) ? MAX_V : bus.din;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_TOGGLE: q_next = toggled;
                MODE_UP: begin
                    // Values above MAX (reachable via toggle mode) wrap straight to 0.
                    if (q_reg >= MAX_V) begin
                        q_next  = ZERO_V;
                        tc_next = 1'b1;
                    end else begin
                        q_next = q_reg + ONE_V;
                    end
                end
                MODE_DOWN: begin
                    if (q_reg == ZERO_V) begin
                        q_next  = MAX_V;
                        tc_next = 1'b1;
                    end else if (q_reg > MAX_V) begin
                        q_next = MAX_V;
                    end else begin
                        q_next = q_reg - ONE_V;
                    end
                end
                default: q_next = q_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg  <= RST_V;
            tc_reg <= 1'b0;
        end else begin
            q_reg  <= q_next;
            tc_reg <= tc_next;
        end
    end

    assign bus.q  = q_reg;
    assign bus.tc = tc_reg;

`ifdef TFF_BANK_OVF_STICKY_EN
    logic ovf_reg;
    logic ovf_next;

    // A wrap on the same edge as a clear keeps the flag set.
    always_comb begin
        ovf_next = ovf_reg;
        if (tc_next) begin
            ovf_next = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_next;
        end
    end

    assign bus.ovf = ovf_reg;
`endif
endmodule

// File: tb/tb_tff_bank_counter.sv
// Directed bench for tff_bank_counter at WIDTH=4, MAX=9, RST_VAL=0.
// Sticky-flag scenarios run only when TFF_BANK_OVF_STICKY_EN is defined.
module tb_tff_bank_counter;
    localparam int WIDTH = 4;
    localparam int MAX   = 9;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;

    tff_bank_counter_if #(.WIDTH(WIDTH)) bus_if ();

    tff_bank_counter #(
        .WIDTH  (WIDTH),
        .MAX    (MAX),
        .RST_VAL(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc=%0d rst=%0b load=%0b din=%h en=%0b mode=%b t=%b -> q=%h tc=%0b",
                 cyc, rst, bus_if.load, bus_if.din, bus_if.en, bus_if.mode, bus_if.t,
                 bus_if.q, bus_if.tc);
    endtask

    task automatic idle_inputs;
        rst          = 1'b0;
        bus_if.en    = 1'b0;
        bus_if.mode  = 2'b11;
        bus_if.t     = 4'h0;
        bus_if.load  = 1'b0;
        bus_if.din   = 4'h0;
`ifdef TFF_BANK_OVF_STICKY_EN
        bus_if.ovf_clr = 1'b0;
`endif
    endtask

    task automatic test_reset;
        idle_inputs();
        rst         = 1'b1;
        bus_if.load = 1'b1;
        bus_if.din  = 4'h5;
        bus_if.en   = 1'b1;
        bus_if.mode = 2'b01;
        step();
        total++;
        if (bus_if.q !== 4'h0) begin bad++; $display("FAIL reset_q got=%h exp=0", bus_if.q); end
        total++;
        if (bus_if.qbar !== 4'hF) begin bad++; $display("FAIL reset_qbar got=%h exp=f", bus_if.qbar); end
        total++;
        if (bus_if.tc !== 1'b0) begin bad++; $display("FAIL reset_tc got=%b exp=0", bus_if.tc); end
`ifdef TFF_BANK_OVF_STICKY_EN
        total++;
        if (bus_if.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus_if.ovf); end
`endif
        idle_inputs();
    endtask

    task automatic test_count_up;
        logic [3:0] exp_q;
        logic       exp_tc;
        bus_if.en   = 1'b1;
        bus_if.mode = 2'b01;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_q  = (i == 10) ? 4'd0 : 4'(i);
            exp_tc = (i == 10);
            total++;
            if (bus_if.q !== exp_q) begin bad++; $display("FAIL up_q step=%0d got=%h exp=%h", i, bus_if.q, exp_q); end
            total++;
            if (bus_if.tc !== exp_tc) begin bad++; $display("FAIL up_tc step=%0d got=%b exp=%b", i, bus_if.tc, exp_tc); end
            total++;
            if (bus_if.qbar !== ~exp_q) begin bad++; $display("FAIL up_qbar step=%0d got=%h exp=%h", i, bus_if.qbar, ~exp_q); end
        end
        idle_inputs();
    endtask

    task automatic test_count_down;
        bus_if.load = 1'b1;
        bus_if.din  = 4'h1;
        step();
        total++;
        if (bus_if.q !== 4'h1) begin bad++; $display("FAIL down_load got=%h exp=1", bus_if.q); end
        bus_if.load = 1'b0;
        bus_if.en   = 1'b1;
        bus_if.mode = 2'b10;
        step();
        total++;
        if (bus_if.q !== 4'h0 || bus_if.tc !== 1'b0) begin bad++; $display("FAIL down_to0 got q=%h tc=%b exp q=0 tc=0", bus_if.q, bus_if.tc); end
        step();
        total++;
        if (bus_if.q !== 4'h9 || bus_if.tc !== 1'b1) begin bad++; $display("FAIL down_wrap got q=%h tc=%b exp q=9 tc=1", bus_if.q, bus_if.tc); end
        step();
        total++;
        if (bus_if.q !== 4'h8 || bus_if.tc !== 1'b0) begin bad++; $display("FAIL down_after got q=%h tc=%b exp q=8 tc=0", bus_if.q, bus_if.tc); end
        idle_inputs();
    endtask

    task automatic test_toggle;
        bus_if.load = 1'b1;
        bus_if.din  = 4'h0;
        step();
        bus_if.load = 1'b0;
        bus_if.en   = 1'b1;
        bus_if.mode = 2'b00;
        bus_if.t    = 4'b1010;
        step();
        total++;
        if (bus_if.q !== 4'b1010 || bus_if.tc !== 1'b0) begin bad++; $display("FAIL tog_1 got q=%b tc=%b exp q=1010 tc=0", bus_if.q, bus_if.tc); end
        step();
        total++;
        if (bus_if.q !== 4'b0000 || bus_if.tc !== 1'b0) begin bad++; $display("FAIL tog_2 got q=%b tc=%b exp q=0000 tc=0", bus_if.q, bus_if.tc); end
        // Toggle above MAX, then switch to up: wraps to 0 with tc.
        bus_if.t = 4'b1111;
        step();
        total++;
        if (bus_if.q !== 4'hF) begin bad++; $display("FAIL tog_above_max got=%h exp=f", bus_if.q); end
        bus_if.mode = 2'b01;
        step();
        total++;
        if (bus_if.q !== 4'h0 || bus_if.tc !== 1'b1) begin bad++; $display("FAIL up_from_above got q=%h tc=%b exp q=0 tc=1", bus_if.q, bus_if.tc); end
        // Above MAX in down mode clamps to MAX without tc.
        bus_if.mode = 2'b00;
        bus_if.t    = 4'b1100;
        step();
        bus_if.mode = 2'b10;
        step();
        total++;
        if (bus_if.q !== 4'h9 || bus_if.tc !== 1'b0) begin bad++; $display("FAIL down_from_above got q=%h tc=%b exp q=9 tc=0", bus_if.q, bus_if.tc); end
        idle_inputs();
    endtask

    task automatic test_load;
        bus_if.load = 1'b1;
        bus_if.din  = 4'h4;
        step();
        bus_if.load = 1'b0;
        bus_if.en   = 1'b1;
        bus_if.mode = 2'b01;
        step();
        total++;
        if (bus_if.q !== 4'h5) begin bad++; $display("FAIL load_count got=%h exp=5", bus_if.q); end
        bus_if.load = 1'b1;
        bus_if.din  = 4'hC;
        step();
        total++;
        if (bus_if.q !== 4'h9 || bus_if.tc !== 1'b0) begin bad++; $display("FAIL load_clamp got q=%h tc=%b exp q=9 tc=0", bus_if.q, bus_if.tc); end
        bus_if.load = 1'b0;
        step();
        total++;
        if (bus_if.q !== 4'h0 || bus_if.tc !== 1'b1) begin bad++; $display("FAIL load_wrap got q=%h tc=%b exp q=0 tc=1", bus_if.q, bus_if.tc); end
        bus_if.en   = 1'b0;
        bus_if.load = 1'b1;
        bus_if.din  = 4'h3;
        step();
        total++;
        if (bus_if.q !== 4'h3 || bus_if.tc !== 1'b0) begin bad++; $display("FAIL load_en0 got q=%h tc=%b exp q=3 tc=0", bus_if.q, bus_if.tc); end
        bus_if.load = 1'b0;
        step();
        total++;
        if (bus_if.q !== 4'h3) begin bad++; $display("FAIL hold_en0 got=%h exp=3", bus_if.q); end
        bus_if.en   = 1'b1;
        bus_if.mode = 2'b11;
        step();
        total++;
        if (bus_if.q !== 4'h3 || bus_if.tc !== 1'b0) begin bad++; $display("FAIL hold_mode11 got q=%h tc=%b exp q=3 tc=0", bus_if.q, bus_if.tc); end
        idle_inputs();
    endtask

    task automatic test_reset_midcount;
        bus_if.load = 1'b1;
        bus_if.din  = 4'h5;
        step();
        bus_if.load = 1'b0;
        bus_if.en   = 1'b1;
        bus_if.mode = 2'b01;
        step();
        total++;
        if (bus_if.q !== 4'h6) begin bad++; $display("FAIL mid_pre got=%h exp=6", bus_if.q); end
        rst = 1'b1;
        step();
        total++;
        if (bus_if.q !== 4'h0 || bus_if.tc !== 1'b0) begin bad++; $display("FAIL mid_rst got q=%h tc=%b exp q=0 tc=0", bus_if.q, bus_if.tc); end
        idle_inputs();
    endtask

`ifdef TFF_BANK_OVF_STICKY_EN
    task automatic test_ovf;
        rst = 1'b1;
        step();
        idle_inputs();
        bus_if.en   = 1'b1;
        bus_if.mode = 2'b01;
        for (int i = 1; i <= 10; i++) step();
        total++;
        if (bus_if.q !== 4'h0 || bus_if.ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got q=%h ovf=%b exp q=0 ovf=1", bus_if.q, bus_if.ovf); end
        for (int i = 1; i <= 5; i++) begin
            step();
            total++;
            if (bus_if.ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky step=%0d got=%b exp=1", i, bus_if.ovf); end
        end
        bus_if.ovf_clr = 1'b1;
        step();
        total++;
        if (bus_if.q !== 4'h6 || bus_if.ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr got q=%h ovf=%b exp q=6 ovf=0", bus_if.q, bus_if.ovf); end
        bus_if.ovf_clr = 1'b0;
        for (int i = 1; i <= 3; i++) step();
        total++;
        if (bus_if.q !== 4'h9 || bus_if.ovf !== 1'b0) begin bad++; $display("FAIL ovf_pre got q=%h ovf=%b exp q=9 ovf=0", bus_if.q, bus_if.ovf); end
        bus_if.ovf_clr = 1'b1;
        step();
        total++;
        if (bus_if.q !== 4'h0 || bus_if.ovf !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got q=%h ovf=%b exp q=0 ovf=1", bus_if.q, bus_if.ovf); end
        bus_if.ovf_clr = 1'b0;
        for (int i = 1; i <= 6; i++) step();
        total++;
        if (bus_if.q !== 4'h6) begin bad++; $display("FAIL ovf_mid_pre got=%h exp=6", bus_if.q); end
        rst = 1'b1;
        step();
        total++;
        if (bus_if.q !== 4'h0 || bus_if.ovf !== 1'b0) begin bad++; $display("FAIL ovf_rst got q=%h ovf=%b exp q=0 ovf=0", bus_if.q, bus_if.ovf); end
        idle_inputs();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        idle_inputs();
        test_reset();
        test_count_up();
        test_count_down();
        test_toggle();
        test_load();
        test_reset_midcount();
`ifdef TFF_BANK_OVF_STICKY_EN
        test_ovf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
